// File: rtl/imm_ext_stage_pkg.sv
// Shared definitions for the immediate-extension stage: mode codes and FSM states.
package imm_ext_stage_pkg;

  localparam int EXT_SEL_W = 3;

  typedef enum logic [EXT_SEL_W-1:0] {
    EXT_UNSIGNED      = 3'b000,
    EXT_SIGNED        = 3'b001,
    EXT_POS_H         = 3'b010,
    EXT_SIGNED_SHL2   = 3'b011,
    EXT_UNSIGNED_SHL2 = 3'b100
  } ext_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/imm_ext_stage_if.sv
// Handshake/data bundle between the IR field split and the immediate-extension stage.
interface imm_ext_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int NCH   = 2
);
  import imm_ext_stage_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [NCH*IN_W-1:0]      imm_in;
  logic [NCH*EXT_SEL_W-1:0] ext_sel;
  logic                     out_valid;
  logic                     out_ready;
  logic [NCH*OUT_W-1:0]     out_data;
  logic                     err_sticky;
  logic                     err_clr;

  modport master (
    output in_valid, imm_in, ext_sel, out_ready, err_clr,
    input  in_ready, out_valid, out_data, err_sticky
  );

  modport slave (
    input  in_valid, imm_in, ext_sel, out_ready, err_clr,
    output in_ready, out_valid, out_data, err_sticky
  );
endinterface

// File: rtl/imm_ext_stage_lane.sv
// One combinational extension lane: IN_W-bit field to OUT_W-bit result under a 3-bit mode.
module imm_ext_lane
  import imm_ext_stage_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]      imm,
  input  logic [EXT_SEL_W-1:0] sel,
  output logic [OUT_W-1:0]     res,
  output logic                 illegal
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{(OUT_W-IN_W){1'b0}}, imm};
  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (sel)
      EXT_UNSIGNED:      res = zext;
      EXT_SIGNED:        res = sext;
      EXT_POS_H:         res = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_SIGNED_SHL2:   res = sext << 2;
      EXT_UNSIGNED_SHL2: res = zext << 2;
      default:           illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered NCH-channel immediate-extension stage with valid/ready handshake
// and a sticky illegal-mode flag.
module imm_ext_stage
  import imm_ext_stage_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int NCH   = 2
) (
  input logic            clk,
  input logic            rst,
  imm_ext_stage_if.slave bus
);

  logic [NCH*OUT_W-1:0] lane_res;
  logic [NCH-1:0]       lane_ill;
  logic [NCH*OUT_W-1:0] data_q;
  logic                 err_q;
  stage_state_e         state_q, state_d;
  logic                 in_xfer, out_xfer, out_valid;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    imm_ext_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
      .imm     (bus.imm_in[k*IN_W +: IN_W]),
      .sel     (bus.ext_sel[k*EXT_SEL_W +: EXT_SEL_W]),
      .res     (lane_res[k*OUT_W +: OUT_W]),
      .illegal (lane_ill[k])
    );
  end

  assign out_valid = (state_q == ST_FULL);
  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign bus.in_ready   = !rst && (!out_valid || bus.out_ready);
  assign in_xfer        = bus.in_valid && bus.in_ready;
  assign out_xfer       = out_valid && bus.out_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = data_q;
  assign bus.err_sticky = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_xfer)              state_d = ST_FULL;
      ST_FULL:  if (out_xfer && !in_xfer) state_d = ST_EMPTY;
      default:                            state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_xfer) data_q <= lane_res;
      if (in_xfer && (|lane_ill)) err_q <= 1'b1;
      else if (bus.err_clr)       err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage with a scoreboard of expected bundles.
module tb_imm_ext_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_ext_stage_if #(.IN_W(16), .OUT_W(32), .NCH(2)) d ();
  imm_ext_stage_if #(.IN_W(5),  .OUT_W(32), .NCH(3)) p ();

  imm_ext_stage #(.IN_W(16), .OUT_W(32), .NCH(2)) u_dut (.clk(clk), .rst(rst), .bus(d));
  imm_ext_stage #(.IN_W(5),  .OUT_W(32), .NCH(3)) u_par (.clk(clk), .rst(rst), .bus(p));

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned pops  = 0;
  logic [63:0] sb[$];
  logic        err_exp = 1'b0;

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [2:0] m);
    case (m)
      3'd0:    return {16'h0000, x};
      3'd1:    return {{16{x[15]}}, x};
      3'd2:    return {x, 16'h0000};
      3'd3:    return {{14{x[15]}}, x, 2'b00};
      3'd4:    return {14'h0000, x, 2'b00};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven at posedge+1; the handshake is sampled mid-cycle.
  task automatic cycle();
    logic [63:0] e;
    logic        nerr;
    #3;
    nerr = err_exp;
    if (d.out_valid && d.out_ready) begin
      pops++;
      if (sb.size() == 0) check("sb_underflow", 96'd1, 96'd0);
      else begin
        e = sb.pop_front();
        check("sb_data", {32'h0, d.out_data}, {32'h0, e});
      end
    end
    if (d.in_valid && d.in_ready) begin
      sb.push_back({ref16(d.imm_in[31:16], d.ext_sel[5:3]), ref16(d.imm_in[15:0], d.ext_sel[2:0])});
      if (d.ext_sel[5:3] > 3'd4 || d.ext_sel[2:0] > 3'd4) nerr = 1'b1;
      else if (d.err_clr) nerr = 1'b0;
    end else if (d.err_clr) nerr = 1'b0;
    @(posedge clk);
    #1;
    err_exp = nerr;
    check("err_model", {95'h0, d.err_sticky}, {95'h0, err_exp});
  endtask

  logic [2:0]  modes [5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4};
  logic [31:0] mexp  [5] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010, 32'h00020010};
  logic [63:0] bundle_a;

  initial begin
    rst = 1'b1;
    d.in_valid = 1'b0; d.imm_in = '0; d.ext_sel = '0; d.out_ready = 1'b1; d.err_clr = 1'b0;
    p.in_valid = 1'b0; p.imm_in = '0; p.ext_sel = '0; p.out_ready = 1'b1; p.err_clr = 1'b0;
    @(posedge clk); #1;
    check("in_ready_in_rst", {95'h0, d.in_ready}, 96'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {95'h0, d.in_ready}, 96'd1);
    check("rst_out_valid", {95'h0, d.out_valid}, 96'd0);
    check("rst_out_data", {32'h0, d.out_data}, 96'd0);

    // Mode sweep on both channels
    for (int unsigned i = 0; i < 5; i++) begin
      d.in_valid = 1'b1; d.imm_in = {16'h8004, 16'h8004}; d.ext_sel = {modes[i], modes[i]};
      cycle();
      check("mode_ch0", {64'h0, d.out_data[31:0]}, {64'h0, mexp[i]});
      check("mode_ch1", {64'h0, d.out_data[63:32]}, {64'h0, mexp[i]});
    end
    d.in_valid = 1'b0;
    cycle();

    // Backpressure: A held while B waits
    d.out_ready = 1'b0; d.in_valid = 1'b1;
    d.imm_in = {16'h1234, 16'h00FF}; d.ext_sel = {3'd0, 3'd1};
    bundle_a = {32'h00001234, 32'h000000FF};
    cycle();
    d.imm_in = {16'hFFFF, 16'h7FFF}; d.ext_sel = {3'd1, 3'd4};
    for (int unsigned i = 0; i < 3; i++) begin
      #2;
      check("bp_in_ready", {95'h0, d.in_ready}, 96'd0);
      cycle();
      check("bp_hold_data", {32'h0, d.out_data}, {32'h0, bundle_a});
      check("bp_hold_valid", {95'h0, d.out_valid}, 96'd1);
    end
    d.out_ready = 1'b1;
    cycle();
    check("bp_swap_valid", {95'h0, d.out_valid}, 96'd1);
    check("bp_swap_data", {32'h0, d.out_data}, {32'h0, 32'hFFFFFFFF, 32'h0001FFFC});
    d.in_valid = 1'b0;
    cycle();
    check("bp_drained", {95'h0, d.out_valid}, 96'd0);

    // Streaming 8 bundles back to back
    pops = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      d.in_valid = 1'b1;
      d.imm_in = {16'(16'hF000 + i), 16'(16'h0100 * i)};
      d.ext_sel = {3'(i % 5), 3'((i + 2) % 5)};
      cycle();
      check("stream_valid", {95'h0, d.out_valid}, 96'd1);
    end
    d.in_valid = 1'b0;
    cycle();
    check("stream_pops", 96'(pops), 96'd8);
    check("stream_empty", {95'h0, d.out_valid}, 96'd0);

    // Illegal mode on channel 1
    d.in_valid = 1'b1; d.imm_in = {16'h5555, 16'h8004}; d.ext_sel = {3'b110, 3'd1};
    cycle();
    check("ill_ch0", {64'h0, d.out_data[31:0]}, {64'h0, 32'hFFFF8004});
    check("ill_ch1", {64'h0, d.out_data[63:32]}, 96'd0);
    check("ill_err_set", {95'h0, d.err_sticky}, 96'd1);
    d.err_clr = 1'b1; d.ext_sel = {3'd0, 3'b101};
    cycle();
    check("ill_set_wins", {95'h0, d.err_sticky}, 96'd1);
    d.in_valid = 1'b0;
    cycle();
    check("ill_lone_clr", {95'h0, d.err_sticky}, 96'd0);
    d.err_clr = 1'b0;
    cycle();

    // Parametrised instance
    p.in_valid = 1'b1; p.imm_in = {5'h1F, 5'h10, 5'h10}; p.ext_sel = {3'd2, 3'd0, 3'd1};
    cycle();
    p.in_valid = 1'b0;
    check("par_data", p.out_data, {32'hF8000000, 32'h00000010, 32'hFFFFFFF0});
    check("par_valid", {95'h0, p.out_valid}, 96'd1);

    // Asynchronous reset while FULL with err set
    d.out_ready = 1'b0; d.in_valid = 1'b1; d.imm_in = {16'h0001, 16'h0002}; d.ext_sel = {3'd7, 3'd1};
    cycle();
    d.in_valid = 1'b0;
    check("pre_rst_err", {95'h0, d.err_sticky}, 96'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {95'h0, d.out_valid}, 96'd0);
    check("arst_data", {32'h0, d.out_data}, 96'd0);
    check("arst_err", {95'h0, d.err_sticky}, 96'd0);
    check("arst_in_ready", {95'h0, d.in_ready}, 96'd0);
    sb.delete();
    err_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {95'h0, d.in_ready}, 96'd1);
    d.out_ready = 1'b1; d.in_valid = 1'b1; d.imm_in = {16'h8000, 16'h0001}; d.ext_sel = {3'd3, 3'd2};
    cycle();
    check("post_rst_load", {32'h0, d.out_data}, {32'h0, 32'hFFFE0000, 32'h00010000});
    d.in_valid = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Parametrised, registered immediate-extension stage for the multi-cycle MIPS datapath.
- Takes NCH immediate fields of IN_W bits each, extends every field to OUT_W bits under a per-channel mode, and holds the results in an output register.
- Sits between the instruction-register field split and the ALU-B / PC-offset muxes.
- A valid/ready handshake lets the control FSM stall consumption across multi-cycle states.
- Adds branch/jump word-offset modes, defined illegal-mode behaviour and a sticky error flag.

## Interface
- IN_W, 16, width of each input immediate field (≥ 1)
- OUT_W, 32, width of each extended result (must be ≥ IN_W + 2)
- NCH, 2, number of independent channels (≥ 1)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input bundle valid
- in_ready  output  1  stage can accept the bundle this cycle
- imm_in  input  NCH*IN_W  packed fields; channel k at [k*IN_W +: IN_W]
- ext_sel  input  NCH*3  packed per-channel modes; channel k at [k*3 +: 3]
- out_valid  output  1  out_data holds a valid bundle
- out_ready  input  1  consumer accepts the bundle this cycle
- out_data  output  NCH*OUT_W  packed results; channel k at [k*OUT_W +: OUT_W]
- err_sticky  output  1  set by any accepted illegal mode; cleared by err_clr
- err_clr  input  1  synchronous clear of err_sticky

## Operation
Per-channel modes, with x = IN_W-bit field, computed combinationally, then registered:
- 3'b000 UNSIGNED: zero-extend x.
- 3'b001 SIGNED: sign-extend x from bit IN_W-1.
- 3'b010 POS_H: x in bits [OUT_W-1 -: IN_W], zeros below.
- 3'b011 SIGNED_SHL2: sign-extend, then shift left 2. Bits above OUT_W are discarded; since OUT_W ≥ IN_W+2, nothing is lost.
- 3'b100 UNSIGNED_SHL2: zero-extend, then shift left 2.
- 3'b101..3'b111 illegal: channel result is all zeros; flags an error on transfer.

Handshake and state machine:
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready. This gives full throughput with no bubble. in_ready is forced 0 while rst is high.
- Input transfer: in_valid && in_ready.
- Output transfer: out_valid && out_ready.
- EMPTY + input transfer → FULL; out_data loads the new results.
- FULL + output transfer, no input transfer → EMPTY; out_data holds its last value.
- FULL + output transfer + input transfer (same cycle) → stays FULL; out_data is replaced by the new bundle.
- FULL + !out_ready → out_data and out_valid are frozen; imm_in/ext_sel changes are ignored.
- in_valid low: no state change.

Error flag:
- err_sticky sets on the cycle after an input transfer in which any channel's ext_sel is illegal.
- err_clr clears it. If a set and err_clr occur in the same cycle, set wins.

Reset:
- Asynchronous; takes effect immediately, including mid-bundle.
- out_valid=0, out_data=0, err_sticky=0, state EMPTY.
- Any pending unconsumed bundle is dropped.

## Timing
- Latency: 1 cycle from input transfer to out_valid / out_data.
- Throughput: 1 bundle/cycle while out_ready is held high.
- in_ready depends combinationally on out_ready (the only comb path input→output). The consumer must not make out_ready depend on in_ready.
- First acceptance: the first rising edge after rst deasserts.

## Structure
- Shared package/header (alongside the existing DEFINE constants): mode codes EXT_UNSIGNED, EXT_SIGNED, EXT_POS_H, EXT_SIGNED_SHL2, EXT_UNSIGNED_SHL2; mode width EXT_SEL_W = 3.
- Sub-module imm_ext_lane: purely combinational, one channel, parameters IN_W/OUT_W, outputs the result and an illegal flag.
- imm_ext_stage: generates NCH lanes, ORs the illegal flags, and owns the FSM, output register and err_sticky.

## Test plan
- Reset: assert rst mid-FULL → out_valid=0, out_data=0, err_sticky=0 immediately; in_ready=0 during rst, 1 after.
- Mode sweep (default params):
  - imm 16'h8004, SIGNED → 32'hFFFF8004.
  - UNSIGNED → 32'h00008004.
  - POS_H → 32'h80040000.
  - SIGNED_SHL2 → 32'hFFFE0010.
  - UNSIGNED_SHL2 → 32'h00020010.
- Backpressure:
  - Load bundle A, then hold out_ready=0 for 3 cycles while presenting B → out_data stays A and in_ready=0.
  - Raise out_ready → A consumed and B loaded on the same edge, out_valid stays 1.
- Streaming: in_valid and out_ready held at 1 for 8 bundles → 8 outputs on consecutive cycles, in order, 1-cycle latency.
- Illegal mode:
  - Channel 1 ext_sel=3'b110 → channel 1 output 0, channel 0 correct, err_sticky=1 next cycle.
  - err_clr coincident with a new illegal transfer → err_sticky stays 1.
  - Lone err_clr → err_sticky=0.
- Parametrisation: IN_W=5, OUT_W=32, NCH=3, fields 5'h10 SIGNED / 5'h10 UNSIGNED / 5'h1F POS_H → 32'hFFFFFFF0 / 32'h00000010 / 32'hF8000000.
